// File: rtl/hnmpp_pkg.sv
// Shared defaults and controller state type for the HNMPP hit-map block.
package hnmpp_pkg;

  localparam int HNM_NROWS_DEF  = 256;
  localparam int HNM_SSID_W_DEF = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } hnm_state_e;

endpackage

// File: rtl/hnm_bram.sv
// 1-bit-wide read-first RAM: one write port, one synchronous read port whose
// output register can be cleared so out-of-range reads return 0.
module hnm_bram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic          i_wdata,
  input  logic          i_re,
  input  logic          i_rd_clr,
  input  logic [AW-1:0] i_raddr,
  output logic          o_rdata
);

  logic r_mem [DEPTH];
  logic r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Same-edge read sees the pre-write contents, giving read-first behaviour.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_rdata <= 1'b0;
    else if (i_rd_clr) r_rdata <= 1'b0;
    else if (i_re)     r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/hnmpp.sv
// Hit-map controller: sweeps the map to zero after reset (CLEAR), then serves
// one read and one write per cycle (RUN). Optional probe: HNMPP_TESTRESULT_EN.
module hnmpp
  import hnmpp_pkg::*;
#(
  parameter int NROWS_HNM = HNM_NROWS_DEF,
  parameter int SSID_W    = HNM_SSID_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SSID_W-1:0] SSID,
  input  logic              write,
  input  logic              read,
  output logic              HNM_writeReady,
  output logic              HNM_readReady,
  output logic              HNM_SSIDHit,
  output logic              testResult,
  output hnm_state_e        o_dbg_state
);

  localparam int              AW       = (NROWS_HNM > 1) ? $clog2(NROWS_HNM) : 1;
  localparam logic [AW-1:0]   LAST_ROW = AW'(NROWS_HNM - 1);
  localparam logic [SSID_W:0] NROWS_W  = (SSID_W + 1)'(NROWS_HNM);

  // Handshake: a request is taken on any rising edge where its strobe and the
  // matching ready are both high; there is no back-pressure beyond ready.
  hnm_state_e    r_state;
  hnm_state_e    w_state_nxt;
  logic [AW-1:0] r_clr_ptr;

  logic          w_run;
  logic          w_in_range;
  logic [AW-1:0] w_row;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_waddr;
  logic          w_mem_wdata;
  logic          w_mem_re;
  logic          w_mem_rd_clr;

  assign w_in_range = ({1'b0, SSID} < NROWS_W);
  assign w_row      = SSID[AW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= CLEAR;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_clr_ptr <= '0;
    else if (r_state == CLEAR) r_clr_ptr <= r_clr_ptr + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR: if (r_clr_ptr == LAST_ROW) w_state_nxt = RUN;
      RUN:   w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_run          = (r_state == RUN);
    HNM_writeReady = w_run;
    HNM_readReady  = w_run;
    w_rd_acc       = read & w_run;
    w_wr_acc       = write & w_run;
    w_mem_we       = 1'b1;
    w_mem_waddr    = r_clr_ptr;
    w_mem_wdata    = 1'b0;
    w_mem_re       = w_rd_acc & w_in_range;
    w_mem_rd_clr   = w_rd_acc & ~w_in_range;
    if (w_run) begin
      w_mem_we    = w_wr_acc & w_in_range;
      w_mem_waddr = w_row;
      w_mem_wdata = 1'b1;
    end
  end

  assign o_dbg_state = r_state;

  hnm_bram #(
    .DEPTH (NROWS_HNM),
    .AW    (AW)
  ) u_hnm_bram (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_we     (w_mem_we),
    .i_waddr  (w_mem_waddr),
    .i_wdata  (w_mem_wdata),
    .i_re     (w_mem_re),
    .i_rd_clr (w_mem_rd_clr),
    .i_raddr  (w_row),
    .o_rdata  (HNM_SSIDHit)
  );

`ifdef HNMPP_TESTRESULT_EN
  // Shadow copy of the map so the probe can read every RUN cycle without
  // disturbing the held HNM_SSIDHit value.
  logic w_probe_re;
  logic w_probe_clr;

  assign w_probe_re  = w_run & w_in_range;
  assign w_probe_clr = w_run & ~w_in_range;

  hnm_bram #(
    .DEPTH (NROWS_HNM),
    .AW    (AW)
  ) u_probe_bram (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_we     (w_mem_we),
    .i_waddr  (w_mem_waddr),
    .i_wdata  (w_mem_wdata),
    .i_re     (w_probe_re),
    .i_rd_clr (w_probe_clr),
    .i_raddr  (w_row),
    .o_rdata  (testResult)
  );
`else
  assign testResult = 1'b0;
`endif

endmodule

// File: tb/tb_hnmpp.sv
// Self-checking bench for hnmpp: per-cycle reference model, a vector table,
// and directed sequences for clear length, read-first and reset restart.
module tb_hnmpp;
  import hnmpp_pkg::*;

  localparam int N = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ssid = 8'h00;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic       wr_rdy, rd_rdy, hit, tr;
  hnm_state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the map as a plain array plus clear-progress counter.
  bit ref_mem [N];
  int clr_cnt;
  bit ref_run;
  bit ref_hit;
  bit ref_tr;

  typedef struct {
    bit         rd;
    bit         wr;
    logic [7:0] s;
    bit         exp;
  } vec_t;
  vec_t vt [12];

  hnmpp #(.NROWS_HNM(N), .SSID_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .SSID           (ssid),
    .write          (write),
    .read           (read),
    .HNM_writeReady (wr_rdy),
    .HNM_readReady  (rd_rdy),
    .HNM_SSIDHit    (hit),
    .testResult     (tr),
    .o_dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    ref_run = 1'b0;
    clr_cnt = 0;
    ref_hit = 1'b0;
    ref_tr  = 1'b0;
    foreach (ref_mem[i]) ref_mem[i] = 1'b0;
  endfunction

  function automatic void model_step();
    if (!ref_run) begin
      clr_cnt++;
      if (clr_cnt == N) ref_run = 1'b1;
    end else begin
      ref_tr = ref_mem[ssid];
      if (read)  ref_hit = ref_mem[ssid];
      if (write) ref_mem[ssid] = 1'b1;
    end
  endfunction

  task automatic check_outputs();
    chk("wr_ready", wr_rdy, ref_run);
    chk("rd_ready", rd_rdy, ref_run);
    chk("ssid_hit", hit, ref_hit);
    chk("dbg_state", dbg_state == RUN, ref_run);
`ifdef HNMPP_TESTRESULT_EN
    chk("test_result", tr, ref_tr);
`else
    chk("test_result", tr, 1'b0);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit r, input bit w, input logic [7:0] s);
    read  = r;
    write = w;
    ssid  = s;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    model_reset();
    repeat (n) cycle();
    reset = 1'b1;
  endtask

  task automatic wait_run(input string name, input int exp_len);
    int cnt;
    cnt = 0;
    while (wr_rdy !== 1'b1 && cnt < N + 50) begin
      cycle();
      cnt++;
    end
    chk_int(name, cnt, exp_len);
  endtask

  initial begin
    vt[0]  = '{rd: 1'b0, wr: 1'b1, s: 8'h05, exp: 1'b0};
    vt[1]  = '{rd: 1'b1, wr: 1'b0, s: 8'h05, exp: 1'b1};
    vt[2]  = '{rd: 1'b1, wr: 1'b0, s: 8'h06, exp: 1'b0};
    vt[3]  = '{rd: 1'b1, wr: 1'b1, s: 8'h09, exp: 1'b0};
    vt[4]  = '{rd: 1'b1, wr: 1'b0, s: 8'h09, exp: 1'b1};
    vt[5]  = '{rd: 1'b0, wr: 1'b1, s: 8'h05, exp: 1'b1};
    vt[6]  = '{rd: 1'b1, wr: 1'b0, s: 8'h05, exp: 1'b1};
    vt[7]  = '{rd: 1'b1, wr: 1'b0, s: 8'h0A, exp: 1'b0};
    vt[8]  = '{rd: 1'b0, wr: 1'b0, s: 8'h00, exp: 1'b0};
    vt[9]  = '{rd: 1'b1, wr: 1'b0, s: 8'hFF, exp: 1'b0};
    vt[10] = '{rd: 1'b0, wr: 1'b1, s: 8'hFF, exp: 1'b0};
    vt[11] = '{rd: 1'b1, wr: 1'b0, s: 8'hFF, exp: 1'b1};

    // Reset for 3 cycles, then the clear sweep must take exactly N cycles.
    apply_reset(3);
    wait_run("clear_len", N);

    for (int i = 0; i < N; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      cycle();
      chk("post_clear_zero", hit, 1'b0);
    end
    drive(1'b0, 1'b0, 8'h00);
    cycle();

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].rd, vt[i].wr, vt[i].s);
      cycle();
      chk($sformatf("vec%0d", i), hit, vt[i].exp);
    end
    drive(1'b0, 1'b0, 8'h00);

    // Read-first sweep: first pass old zeros, second pass the ones just set.
    apply_reset(1);
    wait_run("clear_len_rw", N);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) begin
        drive(1'b1, 1'b1, 8'(i));
        cycle();
        chk(p == 0 ? "rw_pass1" : "rw_pass2", hit, p == 1);
      end
    end

    // Reset in the middle of a read sweep wipes every row.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      cycle();
    end
    drive(1'b0, 1'b0, 8'h00);
    apply_reset(1);
    wait_run("clear_len_midrun", N);
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      cycle();
      chk("after_reset_zero", hit, 1'b0);
    end
    drive(1'b0, 1'b0, 8'h00);

    // Reset in the middle of CLEAR restarts the sweep from row 0.
    apply_reset(2);
    repeat (100) cycle();
    apply_reset(1);
    wait_run("clear_len_midclear", N);

    // Requests during CLEAR are dropped.
    apply_reset(1);
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b1, 8'($urandom_range(0, 31)));
      cycle();
    end
    drive(1'b0, 1'b0, 8'h00);
    wait_run("clear_len_drop", N - 200);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      cycle();
      chk("clear_drop_zero", hit, 1'b0);
    end

    // Random traffic with occasional resets, checked against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        drive(1'b0, 1'b0, 8'h00);
        apply_reset(1);
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15))
                                          : 8'($urandom_range(0, 255)));
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hnmpp.md
HNMPP -- requirements
Module: hnmpp

Interface
REQ-001 The block SHALL have parameter NROWS_HNM, default 256, number of hit-map rows (power of two, at most 2^SSID_W).
REQ-002 The block SHALL have parameter SSID_W, default 8, SSID address width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port SSID, input, SSID_W bits, row address for read and write.
REQ-006 The block SHALL have port write, input, 1 bit, request to set the hit bit of row SSID.
REQ-007 The block SHALL have port read, input, 1 bit, request to fetch the hit bit of row SSID.
REQ-008 The block SHALL have port HNM_writeReady, output, 1 bit, high when writes are accepted.
REQ-009 The block SHALL have port HNM_readReady, output, 1 bit, high when reads are accepted.
REQ-010 The block SHALL have port HNM_SSIDHit, output, 1 bit, registered hit bit from the last accepted read.
REQ-011 The block SHALL have port testResult, output, 1 bit, debug probe (see Configuration).

Function
REQ-012 Storage SHALL be an NROWS_HNM x 1-bit hit map, one bit per SSID.
REQ-013 The controller SHALL have two states: CLEAR and RUN.
REQ-014 In CLEAR, the block SHALL write 0 to one row per cycle, from row 0 up to row NROWS_HNM-1, then enter RUN on the next cycle; CLEAR therefore lasts NROWS_HNM cycles.
REQ-015 HNM_writeReady and HNM_readReady SHALL be 1 only in RUN, and 0 in CLEAR.
REQ-016 A write SHALL be accepted when write=1 and HNM_writeReady=1; the row SSID is set to 1, and setting an already-set row is idempotent.
REQ-017 A read SHALL be accepted when read=1 and HNM_readReady=1; HNM_SSIDHit SHALL show the row value one cycle later and hold it until the next accepted read.
REQ-018 A simultaneous read and write to the same row SHALL be read-first: the read returns the old value and the row becomes 1.
REQ-019 An SSID value of NROWS_HNM or above SHALL be ignored for writes, and a read of such a row SHALL return 0.
REQ-020 Read and write requests in CLEAR SHALL be dropped; HNM_SSIDHit holds its value.
REQ-021 Requests SHALL need no handshake beyond ready; one read and one write may be accepted per cycle, back-to-back.

Reset
REQ-022 Asserting reset (0) SHALL asynchronously force state CLEAR, the clear pointer to 0, HNM_SSIDHit=0, testResult=0, HNM_writeReady=0 and HNM_readReady=0.
REQ-023 The clear sweep SHALL begin on the first rising edge after reset deasserts.
REQ-024 Reset asserted mid-CLEAR or mid-RUN SHALL restart the sweep from row 0.

Configuration
REQ-025 With macro HNMPP_TESTRESULT_EN defined, testResult SHALL equal the registered value of row SSID sampled every RUN cycle regardless of read, with one cycle of latency.
REQ-026 Without HNMPP_TESTRESULT_EN, testResult SHALL be tied to 0 and no probe logic is built.

Structure
REQ-027 Package hnmpp_pkg SHALL hold the NROWS_HNM and SSID_W defaults and the state enum {CLEAR, RUN}.
REQ-028 Storage SHALL be the sub-module hnm_bram, a 1-bit-wide read-first RAM with synchronous read and one write port; the controller lives in hnmpp.

Verification
REQ-029 Reset low for 3 cycles then high: the ready outputs SHALL be 0 for 256 cycles then 1; all outputs SHALL be 0 during reset.
REQ-030 After CLEAR, read rows 0..255 with write=0: HNM_SSIDHit SHALL be 0 for every row.
REQ-031 Write SSID=8'h05, then read 8'h05 and 8'h06: HNM_SSIDHit SHALL be 1 then 0, each one cycle after its read.
REQ-032 read=write=1 while SSID sweeps 0..255 twice: the first pass SHALL return all 0 and the second pass all 1.
REQ-033 Set rows, pulse reset low mid-sweep, then read them back: all rows SHALL read 0.
REQ-034 Write and read during CLEAR: both SHALL be dropped, and rows SHALL read 0 after RUN is entered.
